// File: rtl/lpc_window_reader_if.sv
// Bundles the buffer read port, window ROM data and windowed-sample stream of
// lpc_window_reader; master is the reader, slave is the buffer/ROM/consumer side.
interface lpc_window_reader_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic                     frame_done;
    logic signed [DATA_W-1:0] Out_Sample;
    logic        [CNT_W-1:0]  Out_Count;
    logic signed [DATA_W-1:0] win_coef;
    logic signed [DATA_W-1:0] win_sample;
    logic        [CNT_W-1:0]  win_index;
    logic                     win_valid;
    logic                     busy;
    logic                     done;
    logic                     overrun;

    modport master (
        input  frame_done, Out_Sample, win_coef,
        output Out_Count, win_sample, win_index, win_valid, busy, done, overrun
    );

    modport slave (
        output frame_done, Out_Sample, win_coef,
        input  Out_Count, win_sample, win_index, win_valid, busy, done, overrun
    );
endinterface

// File: rtl/lpc_window_reader.sv
// Sweeps the LPC analysis window out of the sample buffer on each frame_done and
// streams Q15-windowed samples (rounded, saturated) with a fixed 2-cycle latency.
module lpc_window_reader #(
    parameter int FRAME_LEN = 240,
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 8
) (
    input logic                 clock,
    input logic                 reset,
    lpc_window_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int                      PW       = 2 * DATA_W + 1;
    localparam logic        [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic signed [PW-1:0]    ROUND    = PW'(1 << (DATA_W - 2));
    localparam logic signed [PW-1:0]    SAT_MAX  = PW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [PW-1:0]    SAT_MIN  = -PW'(1 << (DATA_W - 1));
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     drain_q, drain_d;
    logic                     overrun_q, overrun_d;

    logic                     busy;
    logic                     sweeping;

    logic                     v1_q, v1_d;
    logic [CNT_W-1:0]         idx1_q, idx1_d;

    logic signed [2*DATA_W-1:0] product;
    logic signed [PW-1:0]       rounded;
    logic signed [PW-1:0]       shifted;
    logic signed [DATA_W-1:0]   saturated;

    logic signed [DATA_W-1:0] win_sample_q, win_sample_d;
    logic [CNT_W-1:0]         win_index_q, win_index_d;
    logic                     win_valid_q, win_valid_d;
    logic                     done_q, done_d;

    // NOTE: async reset clears the pipeline valid bits too, so an aborted sweep
    // can never leak a stray win_valid or done after reset releases.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            drain_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            drain_q   <= drain_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path
    // through the case leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        drain_d   = drain_q;
        overrun_d = overrun_q | (bus.frame_done && (state_q != IDLE));
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                drain_d = 1'b0;
                if (bus.frame_done) state_d = SWEEP;
            end
            SWEEP: begin
                drain_d = 1'b0;
                if (count_q == LAST_IDX) begin
                    state_d = DRAIN;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                count_d = '0;
                if (drain_q) state_d = IDLE;
                else         drain_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                drain_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        sweeping = (state_q == SWEEP);
    end

    // Stage 1 tracks which index the buffer/ROM data now on the bus belongs to.
    always_comb begin
        v1_d   = sweeping;
        idx1_d = count_q;

        product   = bus.Out_Sample * bus.win_coef;
        rounded   = $signed({product[2*DATA_W-1], product}) + ROUND;
        shifted   = rounded >>> (DATA_W - 1);
        if (shifted > SAT_MAX)      saturated = OUT_MAX;
        else if (shifted < SAT_MIN) saturated = OUT_MIN;
        else                        saturated = shifted[DATA_W-1:0];

        win_valid_d  = v1_q;
        done_d       = v1_q && (idx1_q == LAST_IDX);
        win_sample_d = v1_q ? saturated : win_sample_q;
        win_index_d  = v1_q ? idx1_q    : win_index_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q         <= 1'b0;
            idx1_q       <= '0;
            win_sample_q <= '0;
            win_index_q  <= '0;
            win_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            v1_q         <= v1_d;
            idx1_q       <= idx1_d;
            win_sample_q <= win_sample_d;
            win_index_q  <= win_index_d;
            win_valid_q  <= win_valid_d;
            done_q       <= done_d;
        end
    end

    assign bus.Out_Count  = count_q;
    assign bus.win_sample = win_sample_q;
    assign bus.win_index  = win_index_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.busy       = busy;
    assign bus.done       = done_q;
    assign bus.overrun    = overrun_q;

endmodule
